// File: rtl/riscv_pkg.sv
// Shared constants for the sequential RV64 control path:
// opcodes, sequencer states and ALU operation classes.
package riscv_pkg;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_LD    = 7'b0000011;
   localparam logic [6:0] OP_SD    = 7'b0100011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_ECALL = 7'b1110011;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   function automatic logic op_supported(input logic [6:0] op);
      return (op == OP_R) || (op == OP_LD) ||
             (op == OP_SD) || (op == OP_BEQ);
   endfunction

endpackage

// File: rtl/seq_ctrl_if.sv
// Instruction/data memory handshake between the sequencer
// (master) and the memory side (slave).
interface seq_ctrl_if;
   logic InstrReq;
   logic InstrReady;
   logic DataReady;
   logic MemRead;
   logic MemWrite;

   modport master (
      output InstrReq, MemRead, MemWrite,
      input  InstrReady, DataReady
   );

   modport slave (
      input  InstrReq, MemRead, MemWrite,
      output InstrReady, DataReady
   );
endinterface

// File: rtl/seq_ctrl_counters.sv
// Retired-instruction and cycle counters, free-running
// and wrapping, cleared by asynchronous reset.
module seq_ctrl_counters #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_instr_en,
   input  logic             i_cycle_en,
   output logic [CNT_W-1:0] o_instr,
   output logic [CNT_W-1:0] o_cycle
);
   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] r_instr;
   logic [CNT_W-1:0] r_cycle;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_instr <= '0;
         r_cycle <= '0;
      end else begin
         if (i_instr_en) r_instr <= r_instr + ONE;
         if (i_cycle_en) r_cycle <= r_cycle + ONE;
      end
   end

   assign o_instr = r_instr;
   assign o_cycle = r_cycle;
endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB
// with memory ready handshakes, halt flags and counters.
module seq_ctrl
   import riscv_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   seq_ctrl_if.master       mem,
   input  logic [6:0]       Opcode,
   input  logic             Zero,
   output logic             IRWrite,
   output logic             PCWrite,
   output logic             PCSrc,
   output logic             ALUSrc,
   output logic [1:0]       ALUClass,
   output logic             MemtoReg,
   output logic             RegWrite,
   output logic             Halted,
   output logic             Illegal,
   output logic [2:0]       State,
   output logic [CNT_W-1:0] InstrCount,
   output logic [CNT_W-1:0] CycleCount
);
   state_t r_state;
   state_t w_next;
   logic   r_halted;
   logic   r_illegal;
   logic   w_is_r, w_is_ld, w_is_sd, w_is_beq;
   logic   w_retire, w_run;
   logic   w_req, w_mrd, w_mwr;

   assign w_is_r   = (Opcode == OP_R);
   assign w_is_ld  = (Opcode == OP_LD);
   assign w_is_sd  = (Opcode == OP_SD);
   assign w_is_beq = (Opcode == OP_BEQ);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:  if (mem.InstrReady) w_next = S_DECODE;
         S_DECODE: w_next = op_supported(Opcode) ? S_EXEC : S_HALT;
         S_EXEC: begin
            if (w_is_ld || w_is_sd) w_next = S_MEM;
            else if (w_is_r)        w_next = S_WB;
            else                    w_next = S_FETCH;
         end
         S_MEM:    if (mem.DataReady) w_next = w_is_ld ? S_WB : S_FETCH;
         S_WB:     w_next = S_FETCH;
         S_HALT:   w_next = S_HALT;
         default:  w_next = S_FETCH;
      endcase
   end

   // Strobes are decoded from the live state so reset silences them at once
   always_comb begin
      w_req    = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      PCSrc    = 1'b0;
      ALUSrc   = 1'b0;
      ALUClass = ALU_ADD;
      w_mrd    = 1'b0;
      w_mwr    = 1'b0;
      MemtoReg = 1'b0;
      RegWrite = 1'b0;
      if (!reset) begin
         case (r_state)
            S_FETCH: begin
               w_req   = 1'b1;
               IRWrite = mem.InstrReady;
               PCWrite = mem.InstrReady;
            end
            S_EXEC: begin
               if (w_is_r) begin
                  ALUClass = ALU_FUNCT;
               end else if (w_is_ld || w_is_sd) begin
                  ALUSrc = 1'b1;
               end else if (w_is_beq) begin
                  ALUClass = ALU_SUB;
                  PCWrite  = Zero;
                  PCSrc    = Zero;
               end
            end
            S_MEM: begin
               w_mrd = w_is_ld;
               w_mwr = w_is_sd;
            end
            S_WB: begin
               RegWrite = 1'b1;
               MemtoReg = w_is_ld;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_halted  <= 1'b0;
         r_illegal <= 1'b0;
      end else if (r_state == S_DECODE && !op_supported(Opcode)) begin
         r_halted  <= 1'b1;
         r_illegal <= (Opcode != OP_ECALL);
      end
   end

   assign w_retire = (r_state inside {S_EXEC, S_MEM, S_WB}) &&
                     (w_next == S_FETCH);
   assign w_run    = (r_state != S_HALT);

   seq_ctrl_counters #(.CNT_W(CNT_W)) u_cnt (
      .clk        (clk),
      .reset      (reset),
      .i_instr_en (w_retire),
      .i_cycle_en (w_run),
      .o_instr    (InstrCount),
      .o_cycle    (CycleCount)
   );

   assign mem.InstrReq = w_req;
   assign mem.MemRead  = w_mrd;
   assign mem.MemWrite = w_mwr;
   assign State        = r_state;
   assign Halted       = r_halted;
   assign Illegal      = r_illegal;
endmodule

// File: tb/tb_seq_ctrl.sv
// Self-checking bench for seq_ctrl: per-instruction state path
// model with random memory waits, plus a 4-bit counter instance.
module tb_seq_ctrl;
   localparam logic [6:0] K_R   = 7'h33;
   localparam logic [6:0] K_LD  = 7'h03;
   localparam logic [6:0] K_SD  = 7'h23;
   localparam logic [6:0] K_BEQ = 7'h63;
   localparam logic [6:0] K_EC  = 7'h73;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [6:0]  Opcode = '0;
   logic        Zero = 1'b0;

   logic        IRWrite, PCWrite, PCSrc, ALUSrc, MemtoReg, RegWrite;
   logic        Halted, Illegal;
   logic [1:0]  ALUClass;
   logic [2:0]  State;
   logic [31:0] InstrCount, CycleCount;

   logic        s_irw, s_pcw, s_pcs, s_als, s_m2r, s_rw, s_hlt, s_ill;
   logic [1:0]  s_cls;
   logic [2:0]  s_st;
   logic [3:0]  s_icnt, s_ccnt;

   int n_checks = 0;
   int n_pass = 0;

   logic [31:0] minst = '0;
   logic [31:0] mcyc = '0;
   logic        m_halt = 1'b0;
   logic        m_ill = 1'b0;

   int obs_mrd, obs_rw, obs_rw_idx, obs_pcw_x;

   seq_ctrl_if bus ();
   seq_ctrl_if bus4 ();

   always #5 clk = ~clk;

   seq_ctrl #(.CNT_W(32)) dut (
      .clk(clk), .reset(reset), .mem(bus),
      .Opcode(Opcode), .Zero(Zero),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
      .ALUSrc(ALUSrc), .ALUClass(ALUClass), .MemtoReg(MemtoReg),
      .RegWrite(RegWrite), .Halted(Halted), .Illegal(Illegal),
      .State(State), .InstrCount(InstrCount), .CycleCount(CycleCount)
   );

   seq_ctrl #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .mem(bus4),
      .Opcode(Opcode), .Zero(Zero),
      .IRWrite(s_irw), .PCWrite(s_pcw), .PCSrc(s_pcs),
      .ALUSrc(s_als), .ALUClass(s_cls), .MemtoReg(s_m2r),
      .RegWrite(s_rw), .Halted(s_hlt), .Illegal(s_ill),
      .State(s_st), .InstrCount(s_icnt), .CycleCount(s_ccnt)
   );

   task automatic drive(input logic rdy, input logic drdy,
                        input logic [6:0] op, input logic z);
      bus.InstrReady  = rdy;
      bus4.InstrReady = rdy;
      bus.DataReady   = drdy;
      bus4.DataReady  = drdy;
      Opcode = op;
      Zero   = z;
   endtask

   // Runs one instruction from its first FETCH cycle; zsel<0 randomizes Zero
   task automatic run_instr(input logic [6:0] op, input int fwait,
                            input int dwait, input int nhalt,
                            input int zsel);
      int ph[$];
      int p, nxt;
      logic rdy, drdy, z, r, ld, sd, bq;
      logic [6:0] opc;
      logic [10:0] exp_s, got_s;
      r = (op == K_R); ld = (op == K_LD);
      sd = (op == K_SD); bq = (op == K_BEQ);
      repeat (fwait + 1) ph.push_back(0);
      ph.push_back(1);
      if (r) begin
         ph.push_back(2); ph.push_back(4);
      end else if (ld) begin
         ph.push_back(2);
         repeat (dwait + 1) ph.push_back(3);
         ph.push_back(4);
      end else if (sd) begin
         ph.push_back(2);
         repeat (dwait + 1) ph.push_back(3);
      end else if (bq) begin
         ph.push_back(2);
      end else begin
         repeat (nhalt) ph.push_back(5);
      end
      obs_mrd = 0; obs_rw = 0; obs_rw_idx = -1; obs_pcw_x = 0;
      for (int i = 0; i < ph.size(); i++) begin
         p   = ph[i];
         nxt = (i == ph.size() - 1) ? -1 : ph[i+1];
         rdy  = (p == 0) ? (nxt != 0) : 1'($urandom_range(0, 1));
         drdy = (p == 3) ? (nxt != 3) : 1'($urandom_range(0, 1));
         z    = (zsel < 0) ? 1'($urandom_range(0, 1)) : (zsel != 0);
         opc  = (p == 0) ? 7'($urandom) : op;
         drive(rdy, drdy, opc, z);
         exp_s = {p == 0, p == 0 && rdy,
                  (p == 0 && rdy) || (p == 2 && bq && z),
                  p == 2 && bq && z,
                  p == 2 && (ld || sd),
                  (p == 2 && r) ? 2'b10 : ((p == 2 && bq) ? 2'b01 : 2'b00),
                  p == 3 && ld, p == 3 && sd, p == 4 && ld, p == 4};
         @(negedge clk);
         got_s = {bus.InstrReq, IRWrite, PCWrite, PCSrc, ALUSrc, ALUClass,
                  bus.MemRead, bus.MemWrite, MemtoReg, RegWrite};
         n_checks++;
         if (State !== 3'(p))
            $display("FAIL state op=%h cyc=%0d got %0d want %0d", op, i, State, p);
         else n_pass++;
         n_checks++;
         if (got_s !== exp_s)
            $display("FAIL strobes op=%h cyc=%0d got %b want %b", op, i, got_s, exp_s);
         else n_pass++;
         n_checks++;
         if ({InstrCount, CycleCount} !== {minst, mcyc})
            $display("FAIL counters got %0d/%0d want %0d/%0d",
                     InstrCount, CycleCount, minst, mcyc);
         else n_pass++;
         n_checks++;
         if ({s_icnt, s_ccnt} !== {minst[3:0], mcyc[3:0]})
            $display("FAIL cnt4 got %0d/%0d want %0d/%0d",
                     s_icnt, s_ccnt, minst[3:0], mcyc[3:0]);
         else n_pass++;
         n_checks++;
         if ({Halted, Illegal} !== {m_halt, m_ill})
            $display("FAIL flags got %b%b want %b%b", Halted, Illegal, m_halt, m_ill);
         else n_pass++;
         obs_mrd += int'(bus.MemRead);
         if (RegWrite) begin obs_rw++; obs_rw_idx = i; end
         if (p == 2 && PCWrite) obs_pcw_x++;
         @(posedge clk); #1;
         if (p != 5) mcyc++;
         if (nxt == -1 && p >= 2 && p <= 4) minst++;
         if (p == 1 && !(r || ld || sd || bq)) begin
            m_halt = 1'b1;
            m_ill  = (op != K_EC);
         end
      end
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #2;
      n_checks++;
      if ({Halted, Illegal, State, InstrCount, CycleCount} !== '0)
         $display("FAIL reset_clear got h=%b i=%b st=%0d ic=%0d cc=%0d",
                  Halted, Illegal, State, InstrCount, CycleCount);
      else n_pass++;
      @(posedge clk); #1;
      reset = 1'b0;
      minst = '0; mcyc = '0; m_halt = 1'b0; m_ill = 1'b0;
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b1, K_BEQ, 1'b1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({bus.InstrReq, IRWrite, PCWrite, PCSrc, bus.MemRead,
           bus.MemWrite, RegWrite} !== 7'b0)
         $display("FAIL reset_strobes got req=%b irw=%b pcw=%b want 0",
                  bus.InstrReq, IRWrite, PCWrite);
      else n_pass++;
      n_checks++;
      if ({State, InstrCount, CycleCount, Halted, Illegal} !== '0)
         $display("FAIL reset_state got st=%0d ic=%0d cc=%0d want 0",
                  State, InstrCount, CycleCount);
      else n_pass++;
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      n_checks++;
      if (bus.InstrReq !== 1'b1)
         $display("FAIL req_after_reset got %b want 1", bus.InstrReq);
      else n_pass++;
   endtask

   task automatic test_add();
      run_instr(K_R, 0, 0, 0, -1);
      n_checks++;
      if (obs_rw !== 1 || obs_rw_idx !== 3)
         $display("FAIL add_regwrite got n=%0d idx=%0d want 1/3", obs_rw, obs_rw_idx);
      else n_pass++;
      n_checks++;
      if (InstrCount !== 32'd1)
         $display("FAIL add_icount got %0d want 1", InstrCount);
      else n_pass++;
   endtask

   task automatic test_ld_wait();
      logic [31:0] c0;
      c0 = CycleCount;
      run_instr(K_LD, 0, 2, 0, -1);
      n_checks++;
      if (obs_mrd !== 3)
         $display("FAIL ld_memread got %0d want 3", obs_mrd);
      else n_pass++;
      n_checks++;
      if (CycleCount - c0 !== 32'd7)
         $display("FAIL ld_latency got %0d want 7", CycleCount - c0);
      else n_pass++;
   endtask

   task automatic test_beq();
      logic [31:0] c0;
      for (int zz = 1; zz >= 0; zz--) begin
         c0 = CycleCount;
         run_instr(K_BEQ, 0, 0, 0, zz);
         n_checks++;
         if (obs_pcw_x !== zz)
            $display("FAIL beq_pcwrite z=%0d got %0d want %0d", zz, obs_pcw_x, zz);
         else n_pass++;
         n_checks++;
         if (CycleCount - c0 !== 32'd3)
            $display("FAIL beq_latency got %0d want 3", CycleCount - c0);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      logic [6:0] ops [4];
      ops[0] = K_R; ops[1] = K_LD; ops[2] = K_SD; ops[3] = K_BEQ;
      for (int k = 0; k < 40; k++)
         run_instr(ops[$urandom_range(0, 3)], $urandom_range(0, 3),
                   $urandom_range(0, 3), 0, -1);
   endtask

   task automatic test_halt();
      run_instr(7'h7F, 1, 0, 5, -1);
      pulse_reset();
      run_instr(K_EC, 0, 0, 3, -1);
      pulse_reset();
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 1'b1, 7'h11, 1'b0);
      @(posedge clk); #1;
      drive(1'b0, 1'b1, K_SD, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      drive(1'b0, 1'b0, K_SD, 1'b0);
      @(negedge clk);
      n_checks++;
      if (State !== 3'd3 || bus.MemWrite !== 1'b1)
         $display("FAIL sd_in_mem got st=%0d mw=%b want 3/1", State, bus.MemWrite);
      else n_pass++;
      #1 reset = 1'b1;
      #1;
      n_checks++;
      if ({bus.MemWrite, RegWrite, PCWrite} !== 3'b0)
         $display("FAIL midreset_strobes got mw=%b rw=%b pcw=%b want 0",
                  bus.MemWrite, RegWrite, PCWrite);
      else n_pass++;
      n_checks++;
      if ({State, InstrCount, CycleCount, s_icnt, s_ccnt} !== '0)
         $display("FAIL midreset_clear got st=%0d ic=%0d cc=%0d want 0",
                  State, InstrCount, CycleCount);
      else n_pass++;
      @(posedge clk); #1;
      reset = 1'b0;
      minst = '0; mcyc = '0; m_halt = 1'b0; m_ill = 1'b0;
      run_instr(K_R, 1, 0, 0, -1);
   endtask

   task automatic test_wrap();
      pulse_reset();
      repeat (16) run_instr(K_R, 0, 0, 0, -1);
      n_checks++;
      if ({s_icnt, s_ccnt} !== 8'h00)
         $display("FAIL wrap4 got %0d/%0d want 0/0", s_icnt, s_ccnt);
      else n_pass++;
      n_checks++;
      if ({InstrCount, CycleCount} !== {32'd16, 32'd64})
         $display("FAIL wrap32 got %0d/%0d want 16/64", InstrCount, CycleCount);
      else n_pass++;
   endtask

   initial begin
      drive(1'b0, 1'b0, 7'h00, 1'b0);
      test_reset();
      test_add();
      test_ld_wait();
      test_beq();
      test_random();
      test_halt();
      test_reset_mid();
      test_wrap();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/seq_ctrl.md
# seq_ctrl

Multi-cycle control sequencer for the sequential RV64 processor. Steps each instruction through FETCH, DECODE, EXEC, MEM and WB, driving the enables for the IR, PC, register file and data memory. Handles the instruction and data memory ready handshakes and keeps retired-instruction and cycle counters. Sits beside `decode`: it consumes the IR opcode and ALU `Zero` flag, and its `RegWrite` strobe feeds the register file write port.

## Interface
Parameters:
- `CNT_W`, 32: width of the instruction and cycle counters.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `Opcode`  in  7  `Instr[6:0]` from the IR; valid from DECODE onward.
- `Zero`  in  1  ALU zero flag; sampled in EXEC.
- `InstrReady`  in  1  instruction memory has data this cycle.
- `DataReady`  in  1  data memory read/write completes this cycle.
- `InstrReq`  out  1  instruction fetch request.
- `IRWrite`  out  1  load IR and latch OldPC.
- `PCWrite`  out  1  update PC.
- `PCSrc`  out  1  0: PC+4; 1: OldPC+ImmExt.
- `ALUSrc`  out  1  0: ReadData2; 1: ImmExt.
- `ALUClass`  out  2  00 add, 01 sub, 10 funct-decoded.
- `MemRead`  out  1  data memory read request.
- `MemWrite`  out  1  data memory write request.
- `MemtoReg`  out  1  writeback source; 1 selects memory data.
- `RegWrite`  out  1  register file write strobe.
- `Halted`  out  1  sticky; set by ECALL or an illegal opcode.
- `Illegal`  out  1  sticky; set only by an unsupported opcode.
- `State`  out  3  current state, for debug.
- `InstrCount`  out  CNT_W  retired instruction count.
- `CycleCount`  out  CNT_W  cycles since reset, excluding HALT.

## Operation
State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 recover to FETCH.

Paths by opcode:
- R-type 0110011: FETCH → DECODE → EXEC → WB → FETCH.
- LD 0000011: FETCH → DECODE → EXEC → MEM → WB → FETCH.
- SD 0100011: FETCH → DECODE → EXEC → MEM → FETCH.
- BEQ 1100011: FETCH → DECODE → EXEC → FETCH.
- ECALL 1110011: DECODE → HALT, sets Halted.
- Any other opcode: DECODE → HALT, sets Halted and Illegal.

Outputs are combinational from state, `Opcode`, `Zero` and the ready inputs; every strobe is forced to 0 while `reset`=1.
- FETCH:
  - `InstrReq`=1.
  - `IRWrite`=`PCWrite`=`InstrReady`, with `PCSrc`=0.
  - Stays in FETCH while `InstrReady`=0.
- DECODE: all strobes 0.
- EXEC:
  - R-type: `ALUSrc`=0, `ALUClass`=10.
  - LD/SD: `ALUSrc`=1, `ALUClass`=00.
  - BEQ: `ALUSrc`=0, `ALUClass`=01, and `PCWrite`=`PCSrc`=`Zero`.
- MEM:
  - `MemRead` (LD) or `MemWrite` (SD) held at 1 until `DataReady`=1.
  - Leaves MEM on the cycle `DataReady` is sampled high.
- WB: `RegWrite`=1, with `MemtoReg`=1 for LD and 0 for R-type.
- HALT: all strobes 0. Absorbing until reset.

Counters:
- `InstrCount` increments on each transition into FETCH from EXEC, MEM or WB.
- `CycleCount` increments every cycle not in HALT.
- Both wrap from 2^CNT_W−1 to 0.

## Timing
- Reset values:
  - State FETCH.
  - Both counters 0.
  - `Halted`=`Illegal`=0.
  - All strobes 0 during reset.
  - `InstrReq` rises in the first cycle after reset deasserts.
- Minimum latency with zero-wait memories:
  - R-type: 4 cycles.
  - LD: 5 cycles.
  - SD: 4 cycles.
  - BEQ: 3 cycles.
  - Each memory wait cycle adds 1.
- `InstrReady` outside FETCH and `DataReady` outside MEM are ignored.
- Reset mid-instruction: the in-flight instruction is abandoned, with no RegWrite, MemWrite or PCWrite after assertion. Counters clear.
- `InstrCount` updates on the same edge that enters FETCH, so it is visible in the first FETCH cycle.

## Structure
- Shared package `riscv_pkg`:
  - Opcode constants: OP_R, OP_LD, OP_SD, OP_BEQ, OP_ECALL.
  - State encoding constants.
  - ALUClass constants.
- Sub-module `seq_ctrl_counters`: both CNT_W-bit counters with enables and asynchronous reset.

## Test plan
- ADD `0x003100B3`, `InstrReady`=1 every cycle → State sequence 0,1,2,4,0; `RegWrite`=1 only in cycle 4; `InstrCount`=1.
- LD `0x00873683`, `DataReady` held low 2 cycles in MEM → `MemRead`=1 for 3 cycles, then WB with `MemtoReg`=1; total latency 7 cycles.
- BEQ `0x01280863`, with `Zero`=1 and then `Zero`=0 → `PCWrite`=`PCSrc`=1 in EXEC only when `Zero`=1; 3 cycles each.
- Opcode `0x7F` → HALT, `Illegal`=`Halted`=1, `CycleCount` frozen; `reset` pulse clears both flags and returns to FETCH.
- SD `0x00F83823` with reset asserted in MEM → `MemWrite` drops immediately, counters read 0, State=0.
- Preload both counters to 0xFFFFFFFF via hierarchy, retire one R-type → `InstrCount` wraps to 0.
